sm4_key_schedule: RTL and testbench
===================================

# sm4_key_schedule

Sequential SM4 key-expansion controller that drives one 32-bit τ substitution (four `s_box` instances) for 32 cycles to turn a 128-bit master key into the 32 round keys. The round keys are stored in an internal 32×32 key store. The SM4 round datapath then reads them by index, in encrypt (forward) or decrypt (reversed) order. It sits between the digital-envelope key path (the RSA-recovered session key) and the SM4 cipher core.

## Interface
Parameters: none (the SM4 key length and the round count of 32 are fixed).

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `start`  in  1  — request expansion of `mkey`; sampled only when `busy`=0.
- `mkey`  in  128  — master key; bits [127:96] form MK0. Sampled on the accepted-start edge only.
- `busy`  out  1  — expansion in progress.
- `done`  out  1  — one-cycle pulse after round key 31 is stored.
- `key_ready`  out  1  — level; high when the key store holds a complete, consistent schedule.
- `rk_valid`  out  1  — one-cycle strobe; `rk_out`/`rk_idx` carry a newly produced key.
- `rk_out`  out  32  — round key just produced.
- `rk_idx`  out  5  — index i of `rk_out`.
- `rd_addr`  in  5  — key-store read index.
- `rd_dec`  in  1  — 0: read rk[`rd_addr`]; 1: read rk[31−`rd_addr`].
- `rd_data`  out  32  — registered read data.

## Operation
- FSM states:
  - IDLE→RUN on `start`=1.
  - RUN→RUN while round counter i<31.
  - RUN→DONE at i=31.
  - DONE→IDLE unconditionally, or DONE→RUN if `start`=1 in DONE.
- `start` while in RUN: ignored; it is neither queued nor aborts the run.
- Accepted start:
  - Load K0..K3 = MKj ^ FKj, with FK = a3b1bac6, 56aa3350, 677d9197, b27022dc.
  - Clear i and clear `key_ready`.
- Each RUN cycle:
  - t = K1^K2^K3^CK_i.
  - b = τ(t), one `s_box` per byte.
  - L' = b ^ (b<<<13) ^ (b<<<23).
  - rk_i = K0 ^ L'.
  - Write rk_i to store[i], shift K0..K2←K1..K3, K3←rk_i, then i←i+1.
- CK_i is generated arithmetically, not from a table:
  - Byte j (j=0 is MSB) = ((4i+j)·7) mod 256, 8-bit wraparound.
  - Examples: CK0=00070e15, CK1=1c232a31, CK31=646b7279.
- `rk_out`/`rk_idx` are registered copies of rk_i and i. `rk_valid` pulses once per RUN cycle.
- DONE: `done`=1 and `key_ready`←1.
- Read port:
  - `rd_data` ← store[`rd_dec` ? 31−`rd_addr` : `rd_addr`], registered on every edge in every state.
  - Reads during RUN return partially updated contents. Consumers must gate on `key_ready`.
- Reset values: `busy`=0, `done`=0, `key_ready`=0, `rk_valid`=0, `rk_out`=0, `rk_idx`=0, `rd_data`=0, all store entries=0, K0..K3=0, state=IDLE.
- Reset asserted mid-RUN: everything returns to reset values immediately (asynchronous). No `done` is produced, and `key_ready` stays 0 until a full run completes.

## Timing
- Accepted start on edge E0; `busy`=1 from E0 to E32 (32 cycles).
- rk_i is stored and presented (`rk_valid`=1, `rk_idx`=i) after edge E(i+1).
- After E32:
  - `done`=1 and `key_ready`=1.
  - `busy`=0 unless a new start is accepted at E33.
- `done` deasserts after E33.
- Start-to-done latency: 33 edges. Back-to-back throughput: one schedule per 33 cycles.
- Restart from DONE: a start at E33 drops `key_ready` after E33. `done` still pulses for exactly one cycle.
- Read latency: 1 cycle, with the address and `rd_dec` sampled on the same edge.
- The τ/L' path is single-cycle combinational: four `s_box`es in parallel, then XOR/rotate.

## Test plan
- Standard vector: MK=0123456789abcdeffedcba9876543210, one start → rk0=f12186f9, rk1=41662b61, rk31=9124a012; `done` exactly one cycle at E32; `busy` high for 32 cycles.
- Decrypt read: after the vector above, `rd_dec`=1, `rd_addr`=0 → `rd_data`=9124a012 one cycle later; `rd_addr`=31 → f12186f9.
- `start` held high throughout a run with a different `mkey` → run unaffected, results match the first key; a new run begins at E33 (restart-from-DONE) and `key_ready` drops after E33.
- `rst_n` pulsed low at RUN cycle 10 → all outputs and store zero immediately; no `done`; a subsequent start yields the full correct schedule.
- MK=all zeros → rk0 = L'(τ(FK1^FK2^FK3^CK0)) ^ FK0, checked against the model; all 32 `rk_idx` values stream as 0..31 consecutively with no gaps.
- Random keys (≥100) vs. reference model → all 32 keys match on both the stream and the store.

Source files
------------

// File: rtl/sm4_key_schedule.sv
// SM4 key expansion: one tau/L' round per cycle over 32 cycles, round keys kept
// in a 32x32 store that the cipher core reads forward (encrypt) or reversed (decrypt).

module sm4_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_b
);
  localparam logic [0:255][7:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };
  assign o_b = SBOX[i_a];
endmodule

module sm4_key_schedule (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] mkey,
  output logic         busy,
  output logic         done,
  output logic         key_ready,
  output logic         rk_valid,
  output logic [31:0]  rk_out,
  output logic [4:0]   rk_idx,
  input  logic [4:0]   rd_addr,
  input  logic         rd_dec,
  output logic [31:0]  rd_data
);
  localparam logic [31:0] FK0 = 32'ha3b1bac6, FK1 = 32'h56aa3350,
                          FK2 = 32'h677d9197, FK3 = 32'hb27022dc;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state, w_nxt;
  logic [3:0][31:0]   r_k;
  logic [4:0]         r_i;
  logic [31:0][31:0]  r_store;
  logic               w_start_ok;
  logic [7:0]         w_base;
  logic [31:0]        w_ck, w_t, w_b, w_l, w_rk;
  logic [4:0]         w_ra;

  assign w_start_ok = start && (r_state != S_RUN);
  assign busy       = (r_state == S_RUN);
  assign done       = (r_state == S_DONE);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_nxt = S_RUN;
      S_RUN:   if (r_i == 5'd31) w_nxt = S_DONE;
      S_DONE:  w_nxt = start ? S_RUN : S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // CK_i byte j = 7*(4i+j) mod 256; 8-bit arithmetic gives the wrap for free
  assign w_base = {1'b0, r_i, 2'b00};
  assign w_ck[31:24] = w_base * 8'd7;
  assign w_ck[23:16] = w_base * 8'd7 + 8'd7;
  assign w_ck[15:8]  = w_base * 8'd7 + 8'd14;
  assign w_ck[7:0]   = w_base * 8'd7 + 8'd21;

  assign w_t = r_k[1] ^ r_k[2] ^ r_k[3] ^ w_ck;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    sm4_sbox u_sbox (.i_a(w_t[8*g +: 8]), .o_b(w_b[8*g +: 8]));
  end

  assign w_l  = w_b ^ {w_b[18:0], w_b[31:19]} ^ {w_b[8:0], w_b[31:9]};
  assign w_rk = r_k[0] ^ w_l;
  assign w_ra = rd_dec ? ~rd_addr : rd_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_i       <= '0;
      r_store   <= '0;
      key_ready <= 1'b0;
      rk_valid  <= 1'b0;
      rk_out    <= '0;
      rk_idx    <= '0;
      rd_data   <= '0;
    end else begin
      r_state  <= w_nxt;
      rk_valid <= (r_state == S_RUN);
      rd_data  <= r_store[w_ra];
      if (w_start_ok) begin
        r_k[0]    <= mkey[127:96] ^ FK0;
        r_k[1]    <= mkey[95:64]  ^ FK1;
        r_k[2]    <= mkey[63:32]  ^ FK2;
        r_k[3]    <= mkey[31:0]   ^ FK3;
        r_i       <= '0;
        key_ready <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_k[2:0]       <= r_k[3:1];
        r_k[3]         <= w_rk;
        r_store[r_i]   <= w_rk;
        r_i            <= r_i + 5'd1;
        rk_out         <= w_rk;
        rk_idx         <= r_i;
        if (r_i == 5'd31) key_ready <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sm4_key_schedule.sv
// Scoreboard bench for sm4_key_schedule: stimulus queues expected round keys,
// a negedge monitor pops and compares every rk_valid strobe.

module tb_sm4_key_schedule;
  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, rd_dec = 1'b0;
  logic [127:0] mkey = '0;
  logic [4:0]   rd_addr = '0;
  logic         busy, done, key_ready, rk_valid;
  logic [31:0]  rk_out, rd_data;
  logic [4:0]   rk_idx;

  localparam logic [127:0] STD_KEY = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] ALT_KEY = 128'h00112233445566778899aabbccddeeff;

  localparam logic [0:255][7:0] SB = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  int            checks = 0, errors = 0;
  logic [36:0]   exp_q[$];
  logic [36:0]   mon_e;
  logic [1023:0] last_rk;

  sm4_key_schedule dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mkey(mkey),
    .busy(busy), .done(done), .key_ready(key_ready),
    .rk_valid(rk_valid), .rk_out(rk_out), .rk_idx(rk_idx),
    .rd_addr(rd_addr), .rd_dec(rd_dec), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Reference key expansion straight from the algorithm description
  function automatic logic [1023:0] expand(input logic [127:0] mk);
    logic [31:0] k [4];
    logic [31:0] ck, t, b, rk;
    logic [1023:0] res;
    k[0] = mk[127:96] ^ 32'ha3b1bac6;
    k[1] = mk[95:64]  ^ 32'h56aa3350;
    k[2] = mk[63:32]  ^ 32'h677d9197;
    k[3] = mk[31:0]   ^ 32'hb27022dc;
    res = '0;
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4*i + j) * 7) % 256);
      t = k[1] ^ k[2] ^ k[3] ^ ck;
      for (int j = 0; j < 4; j++) b[8*j +: 8] = SB[t[8*j +: 8]];
      rk = k[0] ^ b ^ rotl(b, 13) ^ rotl(b, 23);
      res[32*i +: 32] = rk;
      k[0] = k[1]; k[1] = k[2]; k[2] = k[3]; k[3] = rk;
    end
    return res;
  endfunction

  task automatic push_exp(input logic [127:0] mk);
    last_rk = expand(mk);
    for (int i = 0; i < 32; i++) exp_q.push_back({5'(i), last_rk[32*i +: 32]});
  endtask

  always @(negedge clk) begin
    if (rst_n && rk_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rk_unexpected: idx %0d got %h, expected no strobe", rk_idx, rk_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rk_stream", {27'd0, rk_idx, rk_out}, {27'd0, mon_e});
      end
    end
  end

  // Leaves the bench at the negedge just before the accepting edge E0
  task automatic start_run(input logic [127:0] mk);
    @(negedge clk);
    start = 1'b1; mkey = mk;
    push_exp(mk);
  endtask

  // Entered at the negedge after E0; returns at the negedge after E33
  task automatic watch_run(input logic [127:0] nk, input bit hold);
    int nb, dn;
    nb = 0; dn = -1;
    chk("key_ready_cleared", 64'(key_ready), 64'd0);
    for (int n = 0; n <= 40; n++) begin
      if (n > 0) @(negedge clk);
      if (done) begin dn = n; break; end
      if (busy) nb++;
    end
    chk("busy_cycles", 64'(nb), 64'd32);
    chk("done_edge", 64'(dn), 64'd32);
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("key_ready_set", 64'(key_ready), 64'd1);
    if (hold) push_exp(nk);
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
    chk("busy_after_e33", 64'(busy), 64'(hold));
    chk("key_ready_after_e33", 64'(key_ready), 64'(!hold));
    start = 1'b0;
  endtask

  task automatic simple_run(input logic [127:0] mk);
    start_run(mk);
    @(negedge clk);
    start = 1'b0; mkey = {$urandom, $urandom, $urandom, $urandom};
    watch_run('0, 1'b0);
  endtask

  task automatic read_chk(input logic dec, input logic [4:0] a, input logic [31:0] exp, input string nm);
    @(negedge clk); rd_dec = dec; rd_addr = a;
    @(negedge clk); chk(nm, 64'(rd_data), 64'(exp));
  endtask

  // Pipelined sweep of the whole store, alternating forward and reversed indexing
  task automatic store_chk(input logic [1023:0] rk, input bit zero);
    @(negedge clk); rd_dec = 1'b0; rd_addr = 5'd0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("store_read", 64'(rd_data), zero ? 64'd0 : 64'(rk[32*i +: 32]));
      if (i < 31) begin
        rd_dec  = 1'((i + 1) % 2);
        rd_addr = rd_dec ? 5'(30 - i) : 5'(i + 1);
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_key_ready", 64'(key_ready), 64'd0);
    chk("rst_rk_valid", 64'(rk_valid), 64'd0);
    chk("rst_rk_out", 64'(rk_out), 64'd0);
    chk("rst_rk_idx", 64'(rk_idx), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    rst_n = 1'b1;

    // Standard vector and decrypt-order reads
    simple_run(STD_KEY);
    read_chk(1'b1, 5'd0,  32'h9124a012, "dec_addr0");
    read_chk(1'b1, 5'd31, 32'hf12186f9, "dec_addr31");
    read_chk(1'b0, 5'd0,  32'hf12186f9, "enc_addr0");
    read_chk(1'b0, 5'd1,  32'h41662b61, "enc_addr1");
    read_chk(1'b0, 5'd31, 32'h9124a012, "enc_addr31");
    store_chk(last_rk, 1'b0);

    // start held through a run with a different key, then restart from DONE
    start_run(STD_KEY);
    @(negedge clk);
    mkey = ALT_KEY;
    watch_run(ALT_KEY, 1'b1);
    watch_run('0, 1'b0);
    store_chk(last_rk, 1'b0);

    // Asynchronous reset in the middle of a run
    start_run(ALT_KEY);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_rk_valid", 64'(rk_valid), 64'd0);
    chk("midrst_rk_out", 64'(rk_out), 64'd0);
    chk("midrst_rk_idx", 64'(rk_idx), 64'd0);
    chk("midrst_rd_data", 64'(rd_data), 64'd0);
    chk("midrst_key_ready", 64'(key_ready), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_done", 64'(done), 64'd0);
      chk("midrst_no_key_ready", 64'(key_ready), 64'd0);
    end
    store_chk('0, 1'b1);
    simple_run(ALT_KEY);
    store_chk(last_rk, 1'b0);

    // All-zero master key
    simple_run('0);
    store_chk(last_rk, 1'b0);

    // Random keys against the reference model
    for (int r = 0; r < 100; r++) begin
      simple_run({$urandom, $urandom, $urandom, $urandom});
      store_chk(last_rk, 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
